// File: rtl/sprite_pkg.sv
// Shared types for the sprite line renderer: descriptor layout, FSM states
// and the transparent colour index.
package sprite_pkg;

  localparam int DESC_W      = 32;
  localparam int X_LSB       = 22;
  localparam int X_W         = 10;
  localparam int ID_LSB      = 14;
  localparam int ID_W        = 8;
  localparam int ROW_LSB     = 10;
  localparam int ROW_W       = 4;
  localparam int HFLIP_BIT   = 0;
  localparam int TRANSPARENT = 0;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [ID_W-1:0]  sprite_id;
    logic [ROW_W-1:0] row;
    logic             hflip;
  } spr_desc_t;

  typedef enum logic [2:0] {IDLE, POP, LATCH, FETCH, DRAW, DONE} state_t;

  function automatic spr_desc_t decode_desc(input logic [DESC_W-1:0] raw);
    spr_desc_t d;
    d.x         = raw[X_LSB +: X_W];
    d.sprite_id = raw[ID_LSB +: ID_W];
    d.row       = raw[ROW_LSB +: ROW_W];
    d.hflip     = raw[HFLIP_BIT];
    return d;
  endfunction

endpackage

// File: rtl/sprite_row_serializer.sv
// Turns one sprite pixel row into a stream of one pixel per cycle,
// optionally mirrored, flagging the final pixel of the row.
module sprite_row_serializer #(
  parameter int SPR_W = 16,
  parameter int PIX_W = 4,
  parameter int IDX_W = $clog2(SPR_W)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   load,
  input  logic [SPR_W*PIX_W-1:0] row,
  input  logic                   hflip,
  output logic [PIX_W-1:0]       pixel,
  output logic [IDX_W-1:0]       index,
  output logic                   last
);

  logic [SPR_W*PIX_W-1:0] row_q;
  logic                   flip_q;
  logic [IDX_W-1:0]       idx;
  logic                   active;
  logic [IDX_W-1:0]       sel;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      row_q  <= '0;
      flip_q <= 1'b0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      row_q  <= row;
      flip_q <= hflip;
      idx    <= '0;
      active <= 1'b1;
    end else if (active) begin
      idx <= idx + 1'b1;
      if (idx == IDX_W'(SPR_W - 1))
        active <= 1'b0;
    end
  end

  // Mirroring only changes which slot is read; the screen position still follows idx.
  assign sel   = flip_q ? (IDX_W'(SPR_W - 1) - idx) : idx;
  assign pixel = row_q[sel*PIX_W +: PIX_W];
  assign index = idx;
  assign last  = active && (idx == IDX_W'(SPR_W - 1));

endmodule

// File: rtl/sprite_line_renderer.sv
// Drains the sprite FIFO at each scanline start, fetches every sprite's row
// from ROM and writes its opaque pixels into the line buffer.
module sprite_line_renderer
  import sprite_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int LINE_W    = 640,
  parameter int SPR_W     = 16,
  parameter int PIX_W     = 4,
  parameter int MAX_SPR   = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   fifo_e,
  input  logic [BUS_WIDTH-1:0]   fifo_data,
  output logic                   fifo_re,
  output logic [11:0]            rom_addr,
  input  logic [SPR_W*PIX_W-1:0] rom_data,
  output logic                   lb_we,
  output logic [9:0]             lb_addr,
  output logic [PIX_W-1:0]       lb_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(MAX_SPR + 1);
  localparam int IDX_W = $clog2(SPR_W);

  state_t           state;
  logic [X_W-1:0]   desc_x;
  logic             desc_hflip;
  logic [CNT_W-1:0] drawn;
  spr_desc_t        fifo_desc;
  logic             at_limit;
  logic [PIX_W-1:0] ser_pixel;
  logic [IDX_W-1:0] ser_index;
  logic             ser_last;
  logic [10:0]      draw_x;
  logic             in_draw;

  assign fifo_desc = decode_desc(fifo_data[DESC_W-1:0]);
  assign at_limit  = (drawn == CNT_W'(MAX_SPR));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      desc_x     <= '0;
      desc_hflip <= 1'b0;
      drawn      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= POP;
          busy     <= 1'b1;
          overflow <= 1'b0;
          drawn    <= '0;
        end
        POP: begin
          state <= fifo_e ? DONE : LATCH;
          done  <= fifo_e;
        end
        // Descriptors beyond the per-line budget are still popped so the FIFO drains.
        LATCH: if (at_limit) begin
          overflow <= 1'b1;
          state    <= POP;
        end else begin
          desc_x     <= fifo_desc.x;
          desc_hflip <= fifo_desc.hflip;
          state      <= FETCH;
        end
        FETCH: state <= DRAW;
        DRAW: if (ser_last) begin
          drawn <= drawn + 1'b1;
          state <= POP;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sprite_row_serializer #(
    .SPR_W(SPR_W),
    .PIX_W(PIX_W),
    .IDX_W(IDX_W)
  ) u_serializer (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (state == FETCH),
    .row   (rom_data),
    .hflip (desc_hflip),
    .pixel (ser_pixel),
    .index (ser_index),
    .last  (ser_last)
  );

  // Eleven-bit sum so sprites hanging off the right edge are clipped, not wrapped.
  assign draw_x   = {1'b0, desc_x} + 11'(ser_index);
  assign in_draw  = (state == DRAW);
  assign fifo_re  = (state == POP) && !fifo_e;
  assign rom_addr = (state == LATCH && !at_limit) ? {fifo_desc.sprite_id, fifo_desc.row} : '0;
  assign lb_we    = in_draw && (ser_pixel != PIX_W'(TRANSPARENT)) && (draw_x < 11'(LINE_W));
  assign lb_addr  = in_draw ? draw_x[9:0] : '0;
  assign lb_data  = in_draw ? ser_pixel : '0;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer with a behavioural FIFO, a
// registered ROM and a line-buffer monitor.
module tb_sprite_line_renderer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic        fifo_e = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_re;
  logic [11:0] rom_addr;
  logic [63:0] rom_data = '0;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [3:0]  lb_data;
  logic        busy, done, overflow;

  logic [31:0] fifo_q[$];
  logic [63:0] rom_row = '0;
  logic [3:0]  line_buf[0:1023];
  bit          written[0:1023];
  int          wr_count, re_count, bad_re;
  logic [11:0] last_rom;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat;

  sprite_line_renderer dut (
    .Clk(Clk), .Reset(Reset), .start(start), .fifo_e(fifo_e), .fifo_data(fifo_data),
    .fifo_re(fifo_re), .rom_addr(rom_addr), .rom_data(rom_data), .lb_we(lb_we),
    .lb_addr(lb_addr), .lb_data(lb_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    rom_data <= rom_row;
    if (fifo_re && fifo_q.size() > 0) begin
      fifo_data <= fifo_q.pop_front();
      if (fifo_q.size() == 0) fifo_e <= 1'b1;
    end
  end

  always @(negedge Clk) begin
    if (lb_we) begin
      line_buf[lb_addr] = lb_data;
      written[lb_addr]  = 1'b1;
      wr_count++;
    end
    if (fifo_re) re_count++;
    if (fifo_re && fifo_e) bad_re++;
    if (rom_addr != '0) last_rom = rom_addr;
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] make_desc(int x, int id, int row, bit hflip);
    return {10'(x), 8'(id), 4'(row), 9'b0, hflip};
  endfunction

  task automatic push_desc(input logic [31:0] d);
    fifo_q.push_back(d);
    fifo_e = 1'b0;
  endtask

  task automatic clear_monitor();
    for (int i = 0; i < 1024; i++) begin
      line_buf[i] = '0;
      written[i]  = 1'b0;
    end
    wr_count = 0;
    re_count = 0;
    last_rom = '0;
  endtask

  task automatic apply_stimulus(input int budget, output int latency);
    @(negedge Clk);
    start   = 1'b1;
    latency = 0;
    do begin
      @(negedge Clk);
      start = 1'b0;
      latency++;
    end while (!done && latency < budget);
    check_output("done_seen", {31'b0, done}, 32'd1);
    @(negedge Clk);
    check_output("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  int region;

  initial begin
    bad_re = 0;
    clear_monitor();
    #2;
    check_output("rst_fifo_re", {31'b0, fifo_re}, 0);
    check_output("rst_lb_we", {31'b0, lb_we}, 0);
    check_output("rst_busy", {31'b0, busy}, 0);
    check_output("rst_done", {31'b0, done}, 0);
    check_output("rst_overflow", {31'b0, overflow}, 0);
    check_output("rst_rom_addr", {20'b0, rom_addr}, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    // Empty FIFO: done two cycles after start, nothing popped or drawn.
    apply_stimulus(50, lat);
    check_output("empty_latency", lat, 2);
    check_output("empty_re", re_count, 0);
    check_output("empty_wr", wr_count, 0);

    // One sprite, no flip: colours 1..15 at x=100..114.
    clear_monitor();
    for (int i = 0; i < 16; i++) rom_row[i*4 +: 4] = (i < 15) ? 4'(i + 1) : 4'd0;
    push_desc(make_desc(100, 5, 3, 1'b0));
    apply_stimulus(100, lat);
    check_output("one_latency", lat, 21);
    check_output("one_rom_addr", {20'b0, last_rom}, 32'h053);
    check_output("one_re", re_count, 1);
    check_output("one_wr", wr_count, 15);
    for (int i = 0; i < 15; i++)
      check_output($sformatf("one_px%0d", 100 + i), {28'b0, line_buf[100 + i]}, i + 1);
    check_output("one_no115", {31'b0, written[115]}, 0);

    // Same sprite mirrored: x=100 transparent, 15..1 at x=101..115.
    clear_monitor();
    push_desc(make_desc(100, 5, 3, 1'b1));
    apply_stimulus(100, lat);
    check_output("flip_wr", wr_count, 15);
    check_output("flip_no100", {31'b0, written[100]}, 0);
    for (int j = 0; j < 15; j++)
      check_output($sformatf("flip_px%0d", 101 + j), {28'b0, line_buf[101 + j]}, 15 - j);

    // Right-edge clipping at x=630.
    clear_monitor();
    rom_row = 64'h7777_7777_7777_7777;
    push_desc(make_desc(630, 1, 0, 1'b0));
    apply_stimulus(100, lat);
    check_output("clip_wr", wr_count, 10);
    check_output("clip_px639", {28'b0, line_buf[639]}, 7);
    check_output("clip_px630", {28'b0, line_buf[630]}, 7);
    for (int i = 640; i < 646; i++)
      check_output($sformatf("clip_no%0d", i), {31'b0, written[i]}, 0);

    // Ten queued descriptors: eight drawn, two discarded, overflow flagged.
    clear_monitor();
    rom_row = 64'h2222_2222_2222_2222;
    for (int k = 0; k < 10; k++) push_desc(make_desc(k * 40, k, 0, 1'b0));
    @(negedge Clk);
    start = 1'b1;
    lat   = 0;
    do begin
      @(negedge Clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 400);
    check_output("ovf_done_seen", {31'b0, done}, 1);
    check_output("ovf_at_done", {31'b0, overflow}, 1);
    check_output("ovf_latency", lat, 158);
    check_output("ovf_re", re_count, 10);
    check_output("ovf_wr", wr_count, 128);
    check_output("ovf_fifo_e", {31'b0, fifo_e}, 1);
    region = 0;
    for (int i = 320; i < 336; i++) region += written[i];
    for (int i = 360; i < 376; i++) region += written[i];
    check_output("ovf_discard_wr", region, 0);
    check_output("ovf_px280", {28'b0, line_buf[280]}, 2);
    @(negedge Clk);
    check_output("ovf_sticky", {31'b0, overflow}, 1);
    apply_stimulus(50, lat);
    check_output("ovf_cleared", {31'b0, overflow}, 0);

    // Reset in the middle of drawing sprite two.
    clear_monitor();
    rom_row = 64'h3333_3333_3333_3333;
    push_desc(make_desc(0, 1, 0, 1'b0));
    push_desc(make_desc(200, 2, 0, 1'b0));
    push_desc(make_desc(400, 3, 0, 1'b0));
    @(negedge Clk);
    start = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    check_output("mid_pre_we", {31'b0, lb_we}, 1);
    #2 Reset = 1'b0;
    #1;
    check_output("mid_lb_we", {31'b0, lb_we}, 0);
    check_output("mid_lb_addr", {22'b0, lb_addr}, 0);
    check_output("mid_busy", {31'b0, busy}, 0);
    check_output("mid_fifo_re", {31'b0, fifo_re}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (6) @(negedge Clk);
    check_output("mid_re", re_count, 2);
    check_output("mid_left", fifo_q.size(), 1);
    check_output("mid_idle_busy", {31'b0, busy}, 0);
    check_output("never_re_empty", bad_re, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
